// File: rtl/psk_frame_ctrl_if.sv
// Byte-stream bundle between the frame controller, the payload FIFO and the PSK modulator.
// Handshake: mod_empty=0 marks mod_sample valid; a one-cycle mod_read while valid consumes it,
// and the next byte appears the following cycle. pay_read pops the FWFT payload FIFO head.
interface psk_frame_ctrl_if;
  logic [7:0] pay_data;
  logic       pay_empty;
  logic       pay_read;
  logic [7:0] mod_sample;
  logic       mod_empty;
  logic       mod_read;

  modport master (
    input  pay_data, pay_empty, mod_read,
    output pay_read, mod_sample, mod_empty
  );

  modport slave (
    output pay_data, pay_empty, mod_read,
    input  pay_read, mod_sample, mod_empty
  );
endinterface

// File: rtl/psk_frame_ctrl.sv
// Frame sequencer: preamble, sync word and fixed-length payload to the PSK modulator,
// then a forced-empty guard gap so the modulator returns to idle.
module psk_frame_ctrl #(
  parameter int unsigned PREAMBLE_BYTES   = 4,
  parameter logic [7:0]  PREAMBLE_PATTERN = 8'h55,
  parameter logic [15:0] SYNC_WORD        = 16'hD391,
  parameter int unsigned FRAME_BYTES      = 16,
  parameter int unsigned GAP_CYCLES       = 64,
  parameter logic [7:0]  PAD_BYTE         = 8'h00,
  parameter bit          AUTO_START       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              start_i,
  psk_frame_ctrl_if.master  bus,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              underrun_o,
  output logic [2:0]        dbg_state_o
);

  // One byte counter is shared by PREAMBLE, SYNC and PAYLOAD, so size it for the largest.
  localparam int unsigned BYTE_MAX_PS = (PREAMBLE_BYTES > FRAME_BYTES) ? PREAMBLE_BYTES : FRAME_BYTES;
  localparam int unsigned BYTE_MAX    = (BYTE_MAX_PS > 2) ? BYTE_MAX_PS : 2;
  localparam int unsigned CW          = $clog2(BYTE_MAX);
  localparam int unsigned GW          = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SYNC     = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_GAP      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    sample_q, sample_d;
  logic          empty_q, empty_d;
  logic          pay_read_q, pay_read_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;
  logic          consume;
  logic          load_payload;

  assign consume = bus.mod_read && !empty_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sample_d     = sample_q;
    empty_d      = empty_q;
    pay_read_d   = 1'b0;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    load_payload = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i && (start_i || (AUTO_START && !bus.pay_empty))) begin
          state_d    = S_PREAMBLE;
          sample_d   = PREAMBLE_PATTERN;
          empty_d    = 1'b0;
          underrun_d = 1'b0;
          byte_cnt_d = '0;
        end
      end
      S_PREAMBLE: begin
        if (consume) begin
          if (byte_cnt_q == CW'(PREAMBLE_BYTES - 1)) begin
            state_d    = S_SYNC;
            sample_d   = SYNC_WORD[7:0];
            byte_cnt_d = '0;
          end else begin
            sample_d   = PREAMBLE_PATTERN;
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      S_SYNC: begin
        if (consume) begin
          if (byte_cnt_q == '0) begin
            sample_d   = SYNC_WORD[15:8];
            byte_cnt_d = CW'(1);
          end else begin
            state_d      = S_PAYLOAD;
            byte_cnt_d   = '0;
            load_payload = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (consume) begin
          if (byte_cnt_q == CW'(FRAME_BYTES - 1)) begin
            state_d   = S_GAP;
            empty_d   = 1'b1;
            gap_cnt_d = '0;
          end else begin
            byte_cnt_d   = byte_cnt_q + CW'(1);
            load_payload = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        empty_d = 1'b1;
      end
    endcase

    // A payload slot takes the FIFO head if present, otherwise a pad byte and a sticky flag.
    if (load_payload) begin
      if (!bus.pay_empty) begin
        sample_d   = bus.pay_data;
        pay_read_d = 1'b1;
      end else begin
        sample_d   = PAD_BYTE;
        underrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      sample_q   <= 8'h00;
      empty_q    <= 1'b1;
      pay_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sample_q   <= sample_d;
      empty_q    <= empty_d;
      pay_read_q <= pay_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.mod_sample = sample_q;
  assign bus.mod_empty  = empty_q;
  assign bus.pay_read   = pay_read_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign underrun_o     = underrun_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/psk_frame_ctrl.md
Name: psk_frame_ctrl

Overview:
- Frame sequencer between the payload byte FIFO and the PSK modulator's FIFO-style byte interface.
- Each frame it emits a preamble, a 2-byte sync word and a fixed-length payload. It then drives empty for a guard gap so the modulator drops back to idle.
- It keeps the modulator fed without gaps inside a frame and pads with a fill byte on payload underrun.

Parameters:
- PREAMBLE_BYTES, 4, number of preamble bytes (≥1)
- PREAMBLE_PATTERN, 8'h55, preamble byte value
- SYNC_WORD, 16'hD391, sync word; low byte sent first (modulator shifts LSB first)
- FRAME_BYTES, 16, payload bytes per frame (≥1)
- GAP_CYCLES, 64, clocks of forced empty after the last byte is consumed (≥1)
- PAD_BYTE, 8'h00, byte substituted on payload underrun
- AUTO_START, 1, 1 = frame starts when payload FIFO is non-empty; 0 = only on start pulse

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  permits new frame starts; does not affect a frame in progress
- start  in  1  frame start request (single-cycle), sampled in IDLE
- pay_data  in  8  payload FIFO head byte (first-word-fall-through)
- pay_empty  in  1  payload FIFO empty
- pay_read  out  1  one-cycle pop strobe to payload FIFO
- mod_sample  out  8  byte presented to modulator
- mod_empty  out  1  0 = mod_sample valid
- mod_read  in  1  modulator consumed strobe; one-cycle pulse, high the cycle after capture
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of GAP
- underrun  out  1  sticky; set on any pad insertion, cleared at frame start

Behaviour:
- Single clock domain; all outputs are registered.
- Reset values: mod_empty=1, mod_sample=0, pay_read=0, busy=0, frame_done=0, underrun=0, state=IDLE, counters=0. Reset mid-frame aborts immediately.
- States: IDLE, PREAMBLE, SYNC, PAYLOAD, GAP.
- IDLE → PREAMBLE on the edge where enable && (start || (AUTO_START && !pay_empty)).
  - At that edge: mod_sample<=PREAMBLE_PATTERN, mod_empty<=0, underrun<=0, byte counter<=0.
  - start is ignored outside IDLE.
- Byte advance: a mod_read pulse while mod_empty=0 loads the next byte at that edge, so the new byte is visible the following cycle. mod_empty stays 0 for the whole frame.
- mod_read while mod_empty=1 is ignored.
- PREAMBLE:
  - After PREAMBLE_BYTES consumptions, load SYNC_WORD[7:0] and go to SYNC.
  - Otherwise reload the pattern.
- SYNC:
  - The first consumption loads SYNC_WORD[15:8].
  - The second consumption loads the first payload byte and moves to PAYLOAD.
- Payload byte load (also used on SYNC→PAYLOAD):
  - If pay_empty=0: mod_sample<=pay_data and pay_read<=1, high for exactly one cycle after the load edge.
  - If pay_empty=1: mod_sample<=PAD_BYTE, underrun<=1, no pay_read.
- PAYLOAD counts consumptions:
  - The FRAME_BYTES-th consumption sets mod_empty<=1, loads GAP counter=0 and moves to GAP.
  - No further pay_read in this frame.
- GAP:
  - Counts GAP_CYCLES clocks with mod_empty=1.
  - On the last count: frame_done<=1 (one cycle), state IDLE.
  - A new frame may start on the edge after IDLE is entered.
- Counter widths: $clog2 of each bound, min 1 bit; counters saturate-free; each bound is compared to bound-1.
- Constraint (documented, not checked): modulator symbol time ≥2 clocks. GAP_CYCLES ≥ symbol time + 2, so the modulator reaches its idle state.
- Total bytes per frame = PREAMBLE_BYTES + 2 + FRAME_BYTES.

Test Plan:
- Reset mid-PAYLOAD (rst pulse) → next cycle mod_empty=1, busy=0, pay_read=0, underrun=0; no frame_done.
- Defaults with 16 bytes 0x00..0x0F preloaded and the real modulator attached (4 clks/bit, 4 bits/symbol) → serialized byte stream 55,55,55,55,91,D3,00..0F. Then 16 pay_read pulses, frame_done exactly 64 cycles after the 22nd mod_read, underrun=0.
- Underrun: preload only 10 payload bytes → bytes 11–16 = 0x00, exactly 10 pay_read pulses, underrun=1 after the first pad until the next frame start.
- AUTO_START=0, FIFO non-empty, no start → stays IDLE, busy=0. start pulse with enable=0 → ignored. start with enable=1 → mod_sample=0x55, mod_empty=0 on the next cycle.
- start pulses during PREAMBLE/GAP, and mod_read pulses during GAP → no effect on sequence or counts.
- Back-to-back frames (AUTO_START=1, 40 bytes preloaded) → second preamble byte presented the cycle after frame_done. The second frame consumes bytes 16..31 in order.
